// File: rtl/mem_pkg.sv
// Shared encodings for the burst initiator and the memory controller:
// command types on cmd_type and the initiator FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'b00,
    CMD_READ    = 2'b01,
    CMD_WRITE   = 2'b10,
    CMD_REFRESH = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_RESP  = 3'd4,
    ST_REF   = 3'd5
  } state_e;

endpackage

// File: rtl/mem_refresh_timer.sv
// Free-running refresh interval timer with a single (non-queueing) pending flag.
module mem_refresh_timer #(
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic refresh_ack,
  output logic refresh_pending
);

  localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;
  logic          wrap;

  // A wrap that lands while a refresh is still owed is simply dropped.
  always_comb begin
    wrap    = (timer_q == TW'(REFRESH_INTERVAL - 1));
    timer_d = wrap ? '0 : timer_q + 1'b1;
    pend_d  = refresh_ack ? 1'b0 : (pend_q | wrap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  assign refresh_pending = pend_q;

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst initiator: turns one user request into a command plus BURST_LENGTH data
// beats, and interleaves periodic refreshes. Watchdog enabled by MEM_INITIATOR_TIMEOUT_EN.
module mem_burst_initiator
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH       = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int BURST_LENGTH     = 4,
  parameter int REFRESH_INTERVAL = 64,
  parameter int TIMEOUT_CYCLES   = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [BURST_LENGTH*DATA_WIDTH-1:0] req_wdata,
  output logic                             req_ready,
  output logic                             rsp_valid,
  output logic                             rsp_write,
  output logic [BURST_LENGTH*DATA_WIDTH-1:0] rsp_rdata,
  output logic                             rsp_err,
  input  logic                             rsp_ready,
  output logic                             cmd_valid,
  output logic [1:0]                       cmd_type,
  output logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic                             cmd_ready,
  output logic                             write_valid,
  output logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             write_ready,
  input  logic                             read_valid,
  input  logic [DATA_WIDTH-1:0]            read_data,
  output logic                             read_ready,
  output logic                             busy,
  output logic [7:0]                       refresh_count
);

  localparam int BW = $clog2(BURST_LENGTH);
  localparam int PW = BURST_LENGTH * DATA_WIDTH;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [PW-1:0]           wdata_q, wdata_d;
  logic [PW-1:0]           rdata_q, rdata_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [7:0]              rcnt_q, rcnt_d;
  logic                    cmd_valid_q, write_valid_q, read_ready_q, rsp_valid_q;
  logic                    refresh_pending, refresh_ack, timeout;

  mem_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_refresh (
    .clk             (clk),
    .rst_n           (rst_n),
    .refresh_ack     (refresh_ack),
    .refresh_pending (refresh_pending)
  );

`ifdef MEM_INITIATOR_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          hs;

  assign timeout = (wait_q == WW'(TIMEOUT_CYCLES - 1));

  // Counts cycles without progress; any handshake or state move restarts it.
  always_comb begin
    hs = (cmd_valid_q && cmd_ready) || (write_valid_q && write_ready) ||
         (read_ready_q && read_valid) || (rsp_valid_q && rsp_ready) ||
         (req_valid && req_ready);
    wait_d = (hs || (state_d != state_q)) ? '0 : wait_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    beat_d      = beat_q;
    rcnt_d      = rcnt_q;
    refresh_ack = 1'b0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (refresh_pending) begin
          state_d = ST_REF;
        end else if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          beat_d  = '0;
          state_d = ST_CMD;
`ifdef MEM_INITIATOR_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_CMD: begin
        if (cmd_valid_q && cmd_ready) begin
          state_d = write_q ? ST_WDATA : ST_RDATA;
        end else if (timeout) begin
          state_d = ST_RESP;
`ifdef MEM_INITIATOR_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      ST_WDATA: begin
        if (write_valid_q && write_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(BURST_LENGTH - 1)) state_d = ST_RESP;
        end else if (timeout) begin
          state_d = ST_RESP;
`ifdef MEM_INITIATOR_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      ST_RDATA: begin
        if (read_ready_q && read_valid) begin
          rdata_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = read_data;
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(BURST_LENGTH - 1)) state_d = ST_RESP;
        end else if (timeout) begin
          state_d = ST_RESP;
`ifdef MEM_INITIATOR_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      end
      ST_REF: begin
        if (cmd_valid_q && cmd_ready) begin
          refresh_ack = 1'b1;
          rcnt_d      = rcnt_q + 1'b1;
          state_d     = ST_IDLE;
        end else if (timeout) begin
          // Give up for now; the refresh stays owed and is retried from IDLE.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      beat_q        <= '0;
      rcnt_q        <= '0;
      cmd_valid_q   <= 1'b0;
      write_valid_q <= 1'b0;
      read_ready_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
      wait_q        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      beat_q        <= beat_d;
      rcnt_q        <= rcnt_d;
      cmd_valid_q   <= (state_d == ST_CMD) || (state_d == ST_REF);
      write_valid_q <= (state_d == ST_WDATA);
      read_ready_q  <= (state_d == ST_RDATA);
      rsp_valid_q   <= (state_d == ST_RESP);
`ifdef MEM_INITIATOR_TIMEOUT_EN
      wait_q        <= wait_d;
      err_q         <= err_d;
`endif
    end
  end

  always_comb begin
    cmd_type = CMD_IDLE;
    cmd_addr = '0;
    if (state_q == ST_CMD) begin
      cmd_type = write_q ? CMD_WRITE : CMD_READ;
      cmd_addr = addr_q;
    end else if (state_q == ST_REF) begin
      cmd_type = CMD_REFRESH;
    end
  end

  assign req_ready     = (state_q == ST_IDLE) && !refresh_pending;
  assign busy          = (state_q != ST_IDLE);
  assign cmd_valid     = cmd_valid_q;
  assign write_valid   = write_valid_q;
  assign write_data    = wdata_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
  assign read_ready    = read_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign refresh_count = rcnt_q;
`ifdef MEM_INITIATOR_TIMEOUT_EN
  assign rsp_err       = err_q;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: doc/mem_burst_initiator.md
MEM_BURST_INITIATOR -- requirements
Module: mem_burst_initiator

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH 8, command address width; DATA_WIDTH 32, beat width; BURST_LENGTH 4, beats per burst (power of two, >=2); REFRESH_INTERVAL 64, cycles between refresh requests; TIMEOUT_CYCLES 32, watchdog limit.
REQ-002 Ports SHALL be, clock and reset first: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-003 User request: req_valid in 1; req_write in 1, 1 = write and 0 = read; req_addr in ADDR_WIDTH; req_wdata in BURST_LENGTH*DATA_WIDTH, beat i at [i*DATA_WIDTH +: DATA_WIDTH]; req_ready out 1.
REQ-004 User response: rsp_valid out 1; rsp_write out 1; rsp_rdata out BURST_LENGTH*DATA_WIDTH; rsp_err out 1; rsp_ready in 1.
REQ-005 Controller command: cmd_valid out 1; cmd_type out 2, 01 READ, 10 WRITE, 11 REFRESH; cmd_addr out ADDR_WIDTH; cmd_ready in 1.
REQ-006 Controller data: write_valid out 1; write_data out DATA_WIDTH; write_ready in 1; read_valid in 1; read_data in DATA_WIDTH; read_ready out 1.
REQ-007 Status: busy out 1, high when not IDLE; refresh_count out 8, number of refresh commands issued.

Function
REQ-008 The FSM SHALL have states IDLE, CMD, WDATA, RDATA, RESP and REF.
REQ-009 A request SHALL be accepted on req_valid&&req_ready. req_ready SHALL be high only in IDLE with refresh_pending low.
REQ-010 On request accept, the block SHALL capture addr, write flag and wdata, clear beat_idx, and go to CMD next cycle.
REQ-011 In CMD, the block SHALL hold cmd_valid=1, cmd_type and cmd_addr stable until cmd_valid&&cmd_ready. It then goes to WDATA (write) or RDATA (read).
REQ-012 In WDATA, the block SHALL drive write_valid=1 and write_data=beat[beat_idx]. beat_idx increments on write_valid&&write_ready. After beat BURST_LENGTH-1 transfers, go to RESP.
REQ-013 In RDATA, the block SHALL drive read_ready=1 and store read_data into rsp_rdata beat[beat_idx] on read_valid&&read_ready. After beat BURST_LENGTH-1, go to RESP. read_valid outside RDATA SHALL be ignored.
REQ-014 In RESP, the block SHALL hold rsp_valid=1 with rsp_write, rsp_rdata and rsp_err stable until rsp_ready, then return to IDLE. For writes, rsp_rdata SHALL be unchanged.
REQ-015 refresh_timer SHALL count every cycle from 0 to REFRESH_INTERVAL-1 and wrap. On the wrap it SHALL set refresh_pending. A wrap while refresh_pending is already set SHALL be lost (no queueing).
REQ-016 In IDLE with refresh_pending high, the block SHALL enter REF. Refresh SHALL take priority over a simultaneous req_valid.
REQ-017 In REF, the block SHALL drive cmd_valid=1, cmd_type=11 and cmd_addr=0. On cmd_ready it SHALL clear refresh_pending, increment refresh_count (mod 256), and return to IDLE.
REQ-018 A refresh_pending set during a burst SHALL be serviced on the first IDLE cycle after the burst.
REQ-019 beat_idx SHALL be $clog2(BURST_LENGTH) bits wide, and all counters SHALL wrap modulo their width.
REQ-020 cmd_valid, write_valid, read_ready and rsp_valid SHALL be registered outputs that are never asserted in IDLE.

Reset
REQ-021 rst_n low SHALL asynchronously force: state IDLE, all valid/ready outputs 0, busy 0, rsp_err 0, rsp_rdata 0, refresh_count 0, refresh_timer 0, refresh_pending 0, beat_idx 0.
REQ-022 Reset mid-burst SHALL abandon the burst with no response. The first cycle after release SHALL have req_ready=1.

Configuration
REQ-023 The macro MEM_INITIATOR_TIMEOUT_EN SHALL control the watchdog.
- Defined: a wait counter clears on every state change or handshake. If it reaches TIMEOUT_CYCLES-1 in CMD, WDATA or RDATA, the block SHALL go to RESP with rsp_err=1. If the timeout occurs in REF, the block SHALL return to IDLE with refresh_pending kept.
- Undefined: no watchdog logic; rsp_err is tied to 0.

Structure
REQ-024 The cmd_type encodings (IDLE 00, READ 01, WRITE 10, REFRESH 11) and the FSM state encodings SHALL live in the shared package mem_pkg, shared with the controller.
REQ-025 The refresh timer and pending flag SHALL form one sub-module, mem_refresh_timer (outputs refresh_pending; input refresh_ack).

Verification
REQ-026 Write req addr 0x10, wdata beats A0..A3, cmd_ready=1, write_ready=1 -> cmd_type=10, cmd_addr=0x10, then four write beats A0,A1,A2,A3 on consecutive cycles, then rsp_valid with rsp_write=1.
REQ-027 Read req addr 0x10, controller returns A0..A3 after a 2-cycle latency with read_valid gaps -> rsp_rdata = {A3,A2,A1,A0}, rsp_err=0.
REQ-028 write_ready toggles 1,0,1,0 -> write_data holds each beat while stalled; exactly 4 beats transfer.
REQ-029 req_valid asserted at the cycle refresh_pending sets -> REFRESH command first, refresh_count=1, then the request proceeds.
REQ-030 Idle 200 cycles, cmd_ready=1 -> refresh_count=3, spaced 64 cycles apart.
REQ-031 With MEM_INITIATOR_TIMEOUT_EN, read with read_valid held at 0 -> rsp_valid with rsp_err=1 exactly 32 cycles after entering RDATA. Reset asserted mid-WDATA -> all outputs at reset values immediately.
